// File: rtl/wallace_mult_pkg.sv
// Shared sizing helpers for the pipelined Wallace-tree multiplier.
// WALLACE_MULT_ACC_EN adds one accumulate row to the reduction tree.
package wallace_mult_pkg;

    localparam int unsigned WIDTH_DEF      = 32;
    localparam int unsigned RED_STAGES_DEF = 4;

`ifdef WALLACE_MULT_ACC_EN
    localparam int unsigned ACC_ROWS = 1;
`else
    localparam int unsigned ACC_ROWS = 0;
`endif

    // Input register + reduction registers + final-adder register.
    function automatic int unsigned latency_of(input int unsigned red_stages);
        return red_stages + 2;
    endfunction

    // Rows left after applying a number of 3:2 levels; leftovers pass through.
    function automatic int unsigned rows_after(input int unsigned n_rows, input int unsigned levels);
        int unsigned n;
        n = n_rows;
        for (int unsigned k = 0; k < levels; k++) begin
            n = 2 * (n / 3) + n % 3;
        end
        return n;
    endfunction

    function automatic int unsigned csa_levels(input int unsigned n_rows);
        int unsigned n;
        int unsigned lv;
        n  = n_rows;
        lv = 0;
        for (int k = 0; k < 64; k++) begin
            if (n > 2) begin
                n  = 2 * (n / 3) + n % 3;
                lv = lv + 1;
            end
        end
        return lv;
    endfunction

    // Earlier stages absorb the remainder when levels do not split evenly.
    function automatic int unsigned stage_levels(input int unsigned n_lvls, input int unsigned red_stages,
                                                 input int unsigned stage);
        return n_lvls / red_stages + ((stage <= n_lvls % red_stages) ? 32'd1 : 32'd0);
    endfunction

    function automatic int unsigned lvl_end(input int unsigned n_lvls, input int unsigned red_stages,
                                            input int unsigned stage);
        int unsigned e;
        e = 0;
        for (int unsigned s = 1; s <= stage; s++) begin
            e = e + stage_levels(n_lvls, red_stages, s);
        end
        return e;
    endfunction

    function automatic int unsigned level_to_stage(input int unsigned n_lvls, input int unsigned red_stages,
                                                   input int unsigned level);
        int unsigned stg;
        stg = 0;
        for (int unsigned s = 1; s <= red_stages; s++) begin
            if (stg == 0 && level < lvl_end(n_lvls, red_stages, s)) stg = s;
        end
        if (stg == 0) stg = red_stages;
        return stg;
    endfunction

endpackage

// File: rtl/wallace_mult_pipe_if.sv
// Operand/product handshake bundle for wallace_mult_pipe.
// The c addend exists only when WALLACE_MULT_ACC_EN is defined.
interface wallace_mult_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               tc;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] p;
`ifdef WALLACE_MULT_ACC_EN
    logic [2*WIDTH-1:0] c;

    modport master (output in_valid, a, b, tc, c, out_ready, input in_ready, out_valid, p);
    modport slave  (input in_valid, a, b, tc, c, out_ready, output in_ready, out_valid, p);
`else
    modport master (output in_valid, a, b, tc, out_ready, input in_ready, out_valid, p);
    modport slave  (input in_valid, a, b, tc, out_ready, output in_ready, out_valid, p);
`endif
endinterface

// File: rtl/csa_row.sv
// 3:2 carry-save compressor over a whole row; carry is pre-shifted and truncated.
module csa_row #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic [W-1:0] z_i,
    output logic [W-1:0] s_o,
    output logic [W-1:0] c_o
);
    assign s_o = x_i ^ y_i ^ z_i;
    assign c_o = ((x_i & y_i) | (x_i & z_i) | (y_i & z_i)) << 1;
endmodule

// File: rtl/wallace_mult_pipe.sv
// Pipelined Wallace-tree multiplier, WIDTH x WIDTH -> 2*WIDTH, unsigned or two's complement.
// Define WALLACE_MULT_ACC_EN to add the c operand as an extra row (p = a*b + c).
module wallace_mult_pipe
    import wallace_mult_pkg::*;
#(
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned RED_STAGES = RED_STAGES_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    wallace_mult_pipe_if.slave bus
);
    localparam int unsigned PW      = 2 * WIDTH;
    localparam int unsigned N0      = WIDTH + 1 + ACC_ROWS;
    localparam int unsigned NL      = csa_levels(N0);
    localparam int unsigned LATENCY = latency_of(RED_STAGES);
    // Baugh-Wooley correction: 2^WIDTH + 2^(2*WIDTH-1)
    localparam logic [PW-1:0] BW_CORR = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

    logic                    advance_c;
    logic [WIDTH-1:0]        a_q;
    logic [WIDTH-1:0]        b_q;
    logic                    tc_q;
`ifdef WALLACE_MULT_ACC_EN
    logic [PW-1:0]           c_q;
`endif
    logic [LATENCY-1:0]      vld_q;
    logic [LATENCY-1:0]      vld_d;
    logic [PW-1:0]           p_q;
    logic [PW-1:0]           p_d;
    logic [N0-1:0][PW-1:0]   pp_c;

    assign advance_c     = !vld_q[LATENCY-1] || bus.out_ready;
    assign bus.in_ready  = advance_c;
    assign bus.out_valid = vld_q[LATENCY-1];
    assign bus.p         = p_q;
    assign vld_d         = {vld_q[LATENCY-2:0], bus.in_valid & advance_c};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            tc_q <= 1'b0;
`ifdef WALLACE_MULT_ACC_EN
            c_q  <= '0;
`endif
        end else if (advance_c) begin
            a_q  <= bus.a;
            b_q  <= bus.b;
            tc_q <= bus.tc;
`ifdef WALLACE_MULT_ACC_EN
            c_q  <= bus.c;
`endif
        end
    end

    // Partial products; in signed mode terms with exactly one MSB operand bit are inverted.
    always_comb begin
        pp_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            for (int j = 0; j < int'(WIDTH); j++) begin
                pp_c[i][i+j] = (a_q[j] & b_q[i]) ^
                               (tc_q & ((i == int'(WIDTH) - 1) != (j == int'(WIDTH) - 1)));
            end
        end
        pp_c[WIDTH] = tc_q ? BW_CORR : '0;
`ifdef WALLACE_MULT_ACC_EN
        pp_c[WIDTH+1] = c_q;
`endif
    end

    // One generate block per 3:2 level; input comes from the tree, the previous level or a stage register.
    for (genvar l = 0; l < int'(NL); l++) begin : lv
        localparam int unsigned RI = rows_after(N0, l);
        localparam int unsigned RO = rows_after(N0, l + 1);
        localparam int unsigned NT = RI / 3;
        localparam int unsigned S  = level_to_stage(NL, RED_STAGES, l);
        logic [RI-1:0][PW-1:0] din;
        logic [RO-1:0][PW-1:0] dout;

        if (l == 0) begin : g_src_pp
            assign din = pp_c;
        end else if (S != level_to_stage(NL, RED_STAGES, l - 1)) begin : g_src_reg
            assign din = st[S-1].q_q;
        end else begin : g_src_comb
            assign din = lv[l-1].dout;
        end

        for (genvar t = 0; t < int'(NT); t++) begin : csa
            csa_row #(.W(PW)) u_csa (
                .x_i (din[3*t]),
                .y_i (din[3*t+1]),
                .z_i (din[3*t+2]),
                .s_o (dout[2*t]),
                .c_o (dout[2*t+1])
            );
        end
        for (genvar r = 0; r < int'(RI % 3); r++) begin : pass
            assign dout[2*NT+r] = din[3*NT+r];
        end
    end

    // Reduction stage registers; stages without levels just re-time the previous stage.
    for (genvar s = 1; s <= int'(RED_STAGES); s++) begin : st
        localparam int unsigned LE   = lvl_end(NL, RED_STAGES, s);
        localparam int unsigned ROWS = rows_after(N0, LE);
        logic [ROWS-1:0][PW-1:0] q_d;
        logic [ROWS-1:0][PW-1:0] q_q;

        if (stage_levels(NL, RED_STAGES, s) != 0) begin : g_from_lvl
            assign q_d = lv[LE-1].dout;
        end else begin : g_from_stage
            assign q_d = st[s-1].q_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)         q_q <= '0;
            else if (advance_c) q_q <= q_d;
        end
    end

    assign p_d = st[RED_STAGES].q_q[0] + st[RED_STAGES].q_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            p_q   <= '0;
        end else if (advance_c) begin
            vld_q <= vld_d;
            p_q   <= p_d;
        end
    end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Self-checking bench for wallace_mult_pipe: vector table, back-pressure, reset and random scoreboards.
module tb_wallace_mult_pipe;
    localparam int unsigned W    = 32;
    localparam int unsigned R    = 4;
    localparam int unsigned LAT  = R + 2;
    localparam int unsigned W2   = 8;
    localparam int unsigned R2   = 8;
    localparam int unsigned LAT2 = R2 + 2;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        tc;
        logic [63:0] c;
        logic [63:0] p;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    wallace_mult_pipe_if #(.WIDTH(W))  bus ();
    wallace_mult_pipe_if #(.WIDTH(W2)) bus2 ();

    wallace_mult_pipe #(.WIDTH(W),  .RED_STAGES(R))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    wallace_mult_pipe #(.WIDTH(W2), .RED_STAGES(R2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    always #5 clk = ~clk;

    logic [63:0] c1_val;
    logic [63:0] c2_val;
`ifdef WALLACE_MULT_ACC_EN
    assign c1_val = bus.c;
    assign c2_val = 64'(bus2.c);
`else
    assign c1_val = '0;
    assign c2_val = '0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference: sign-extend when tc, multiply, add c, keep 2*w bits.
    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] c, input logic tc, input int w);
        logic [63:0] sa, sb, mask;
        sa = a;
        sb = b;
        if (tc && a[w-1]) sa = a | (64'hFFFF_FFFF_FFFF_FFFF << w);
        if (tc && b[w-1]) sb = b | (64'hFFFF_FFFF_FFFF_FFFF << w);
        mask = (w >= 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        return (sa * sb + c) & mask;
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboards sampled mid-cycle on the falling edge.
    logic [63:0] q1[$];
    logic [63:0] q2[$];
    logic        prev_stall = 1'b0;
    logic [63:0] prev_p     = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q1.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("sb1_p_hold", bus.p, prev_p);
            if (bus.out_valid && bus.out_ready) begin
                if (q1.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sb1_extra_result actual=0x%0h required=none", bus.p);
                end else begin
                    check("sb1_p", bus.p, q1.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready)
                q1.push_back(ref_mul(64'(bus.a), 64'(bus.b), c1_val, bus.tc, W));
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_p     = bus.p;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q2.delete();
        end else begin
            if (bus2.out_valid && bus2.out_ready) begin
                if (q2.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sb2_extra_result actual=0x%0h required=none", bus2.p);
                end else begin
                    check("sb2_p", 64'(bus2.p), q2.pop_front());
                end
            end
            if (bus2.in_valid && bus2.in_ready)
                q2.push_back(ref_mul(64'(bus2.a), 64'(bus2.b), c2_val, bus2.tc, W2));
        end
    end

    // One isolated transaction on the wide DUT: checks latency and product.
    task automatic single(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic tc, input logic [63:0] c, input logic [63:0] exp);
        int n;
        bus.a = a; bus.b = b; bus.tc = tc; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
`ifdef WALLACE_MULT_ACC_EN
        bus.c = c;
`endif
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_latency"}, 64'(n), 64'(LAT));
        check(nm, bus.p, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[$];
        logic [31:0] pa[10], pb[10];
        logic        ptc[10];
        logic [63:0] p_hold;
        int          idx, n_ov, n;
        logic        exp_rdy;

        tbl.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'd0, 64'hFFFF_FFFE_0000_0001});
        tbl.push_back('{32'hFFFF_FFFF, 32'h0000_0005, 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB});
        tbl.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, 64'd0, 64'h4000_0000_0000_0000});
        tbl.push_back('{32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 64'd0, 64'h0});
        tbl.push_back('{32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 64'd0, 64'h0});
        tbl.push_back('{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'd0, 64'hC000_0000_8000_0000});
        tbl.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd0, 64'h1});
        tbl.push_back('{32'hFFFF_FFFE, 32'h8000_0000, 1'b1, 64'd0, 64'h0000_0001_0000_0000});
        tbl.push_back('{32'h0001_0000, 32'h0001_0000, 1'b0, 64'd0, 64'h0000_0001_0000_0000});
        tbl.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 64'd0, 64'h0000_0000_FFFF_FFFF});
        tbl.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 64'd0, 64'h4000_0000_0000_0000});
        tbl.push_back('{32'h0000_0003, 32'h0000_0004, 1'b1, 64'd0, 64'hC});
`ifdef WALLACE_MULT_ACC_EN
        tbl.push_back('{32'h0000_0003, 32'h0000_0004, 1'b1, 64'hFFFF_FFFF_FFFF_FFF4, 64'h0});
        tbl.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000});
`endif

        bus.in_valid = 1'b1; bus.a = 32'd5; bus.b = 32'd7; bus.tc = 1'b0; bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.tc = 1'b0; bus2.out_ready = 1'b1;
`ifdef WALLACE_MULT_ACC_EN
        bus.c = '0; bus2.c = '0;
`endif

        // Reset state with in_valid held high throughout reset.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_p",         bus.p,              64'd0);
        check("rst2_p",        64'(bus2.p),        64'd0);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        n_ov = 0;
        for (int k = 0; k < int'(LAT) + 4; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) n_ov++;
        end
        check("rst_valid_ignored", 64'(n_ov), 64'd0);

        foreach (tbl[i]) single($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].tc, tbl[i].c, tbl[i].p);

        // Back-pressure: 10 back-to-back pairs, consumer stalls on cycles 8..11.
        for (int i = 0; i < 10; i++) begin
            pa[i] = $urandom; pb[i] = $urandom; ptc[i] = 1'($urandom_range(1));
        end
        idx = 0;
        p_hold = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            bus.out_ready = !(cyc >= 8 && cyc <= 11);
            if (idx < 10) begin
                bus.in_valid = 1'b1; bus.a = pa[idx]; bus.b = pb[idx]; bus.tc = ptc[idx];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            exp_rdy = !(cyc >= 8 && cyc <= 11);
            if (cyc < 14) check($sformatf("bp_in_ready_c%0d", cyc), 64'(bus.in_ready), 64'(exp_rdy));
            if (cyc == 8) begin
                check("bp_out_valid_c8", 64'(bus.out_valid), 64'd1);
                check("bp_p_c8", bus.p, ref_mul(64'(pa[2]), 64'(pb[2]), c1_val, ptc[2], W));
                p_hold = bus.p;
            end
            if (cyc > 8 && cyc <= 11) check($sformatf("bp_p_stable_c%0d", cyc), bus.p, p_hold);
            if (bus.in_valid && bus.in_ready) idx++;
            @(posedge clk); #1;
        end
        check("bp_accepted", 64'(idx), 64'd10);
        check("bp_drained", 64'(q1.size()), 64'd0);

        // Random traffic with random back-pressure on the wide DUT.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.a         = pick32();
            bus.b         = pick32();
            bus.tc        = 1'($urandom_range(1));
            bus.out_ready = ($urandom_range(4) != 0);
`ifdef WALLACE_MULT_ACC_EN
            bus.c         = {$urandom, $urandom};
`endif
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (LAT + 4) begin @(posedge clk); #1; end
        check("rand_drained", 64'(q1.size()), 64'd0);

        // Reset mid-stream with a result presented and others in flight.
        for (int k = 0; k < int'(LAT) + 2; k++) begin
            bus.in_valid = 1'b1; bus.a = $urandom | 32'd1; bus.b = $urandom | 32'd1; bus.tc = 1'b0;
`ifdef WALLACE_MULT_ACC_EN
            bus.c = '0;
`endif
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_p",         bus.p,              64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        single("post_rst", 32'd9, 32'hFFFF_FFFD, 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFE5);

        // Narrow DUT: deeper pipe than tree levels, latency then random traffic.
        bus2.a = 8'h80; bus2.b = 8'h80; bus2.tc = 1'b1; bus2.in_valid = 1'b1; bus2.out_ready = 1'b1;
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        n = 1;
        while (!bus2.out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("w8_latency", 64'(n), 64'(LAT2));
        check("w8_minneg_sq", 64'(bus2.p), 64'h4000);
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bus2.in_valid  = ($urandom_range(3) != 0);
            bus2.a         = 8'($urandom);
            bus2.b         = 8'($urandom);
            bus2.tc        = 1'($urandom_range(1));
            bus2.out_ready = ($urandom_range(3) != 0);
`ifdef WALLACE_MULT_ACC_EN
            bus2.c         = 16'($urandom);
`endif
            @(posedge clk); #1;
        end
        bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;
        repeat (LAT2 + 4) begin @(posedge clk); #1; end
        check("w8_drained", 64'(q2.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
